// File: rtl/smart_toilet_pkg.sv
// Shared definitions for the smart-toilet dosing controller.
//   CNT_W_DEFAULT     : default width of duration inputs and counters
//   FLUSH_CYC_DEFAULT : default flush phase length in cycles
//   state_e           : controller FSM states
//   phase_after()     : picks the next non-zero phase in the fixed order
//                       DOSE1, DOSE2, DOSE3, MIX, falling back to FLUSH
package smart_toilet_pkg;

  localparam int unsigned CNT_W_DEFAULT     = 16;
  localparam int unsigned FLUSH_CYC_DEFAULT = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DOSE1 = 3'd1,
    S_DOSE2 = 3'd2,
    S_DOSE3 = 3'd3,
    S_MIX   = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // nz[0..3] flag a non-zero duration for DOSE1, DOSE2, DOSE3, MIX.
  // Only phases strictly after 'from' are candidates; IDLE considers all.
  function automatic state_e phase_after(input state_e from, input logic [3:0] nz);
    if (from == S_IDLE && nz[0])                                return S_DOSE1;
    if ((from inside {S_IDLE, S_DOSE1}) && nz[1])                 return S_DOSE2;
    if ((from inside {S_IDLE, S_DOSE1, S_DOSE2}) && nz[2])        return S_DOSE3;
    if ((from inside {S_IDLE, S_DOSE1, S_DOSE2, S_DOSE3}) && nz[3]) return S_MIX;
    return S_FLUSH;
  endfunction

endpackage

// File: rtl/smart_toilet_dose_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that times one controller phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i this edge (start of a new phase)
//   load_val_i  : phase length in cycles (non-zero when loaded)
//   cnt_o       : current count; equals the cycles left in the phase
//   expire_o    : high during the last cycle of the phase (count == 1)
// The counter stops at zero and never wraps.
module phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/smart_toilet_dose_ctrl.sv
// smart_toilet_dose_ctrl: sequences three dosing pumps, a mix/settle wait
// and a fixed-length flush, with abort and a sticky error flag.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : run request (taken only in IDLE)
//   abort             : cancel request (taken only in DOSE1..3 / MIX)
//   t_dose1..3, t_mix : phase lengths in cycles, 0 skips the phase
//   pump_en[2:0]      : pump enables for solutions 1..3
//   flush_en          : flush valve enable
//   busy, done, err   : run in progress, end-of-run pulse, sticky abort flag
//   state_dbg_o       : current FSM state for observation
// Handshake: start/abort are level-sampled requests; no acknowledge exists,
// a request seen outside its accepting states is simply dropped.
module smart_toilet_dose_ctrl
  import smart_toilet_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_dose1,
  input  logic [CNT_W-1:0] t_dose2,
  input  logic [CNT_W-1:0] t_dose3,
  input  logic [CNT_W-1:0] t_mix,
  output logic [2:0]       pump_en,
  output logic             flush_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output state_e           state_dbg_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t1_q, t2_q, t3_q, tm_q;
  logic [CNT_W-1:0] t1_d, t2_d, t3_d, tm_d;
  logic [CNT_W-1:0] t1_s, t2_s, t3_s, tm_s;
  logic             err_q, err_d;
  logic [2:0]       pump_q, pump_d;
  logic             flush_q, flush_d, busy_q, busy_d, done_q, done_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_expire;
  logic [3:0]       nz;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_val_i (load_val),
    .cnt_o      (tmr_cnt),
    .expire_o   (tmr_expire)
  );

  // In IDLE the live inputs pick the first phase; during a run only the
  // values captured at start matter, so input changes have no effect.
  always_comb begin
    if (state_q == S_IDLE) begin
      t1_s = t_dose1; t2_s = t_dose2; t3_s = t_dose3; tm_s = t_mix;
    end else begin
      t1_s = t1_q;    t2_s = t2_q;    t3_s = t3_q;    tm_s = tm_q;
    end
    nz = {|tm_s, |t3_s, |t2_s, |t1_s};
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t3_d    = t3_q;
    tm_d    = tm_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // start wins over abort here because abort is not looked at
        if (start) begin
          t1_d    = t_dose1;
          t2_d    = t_dose2;
          t3_d    = t_dose3;
          tm_d    = t_mix;
          err_d   = 1'b0;
          state_d = phase_after(S_IDLE, nz);
          load    = 1'b1;
        end
      end
      S_DOSE1, S_DOSE2, S_DOSE3, S_MIX: begin
        if (abort) begin
          state_d = S_FLUSH;
          err_d   = 1'b1;
          load    = 1'b1;
        end else if (tmr_expire) begin
          state_d = phase_after(state_q, nz);
          load    = 1'b1;
        end
      end
      S_FLUSH: if (tmr_expire) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (state_d)
      S_DOSE1: load_val = t1_s;
      S_DOSE2: load_val = t2_s;
      S_DOSE3: load_val = t3_s;
      S_MIX:   load_val = tm_s;
      default: load_val = CNT_W'(FLUSH_CYC);
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    pump_d  = {state_d == S_DOSE3, state_d == S_DOSE2, state_d == S_DOSE1};
    flush_d = (state_d == S_FLUSH);
    busy_d  = (state_d inside {S_DOSE1, S_DOSE2, S_DOSE3, S_MIX, S_FLUSH});
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
      tm_q    <= '0;
      pump_q  <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      t3_q    <= t3_d;
      tm_q    <= tm_d;
      pump_q  <= pump_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pump_en     = pump_q;
  assign flush_en    = flush_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: doc/smart_toilet_dose_ctrl.md
SMART_TOILET_DOSE_CTRL -- requirements
Module: smart_toilet_dose_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of every duration input and internal counter.
REQ-002 Parameter: FLUSH_CYC, default 64, fixed flush phase length in cycles (1..2^CNT_W-1).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  run request, sampled only in IDLE.
REQ-006 Port: abort  input  1  cancel request, sampled only in DOSE1/DOSE2/DOSE3/MIX.
REQ-007 Port: t_dose1  input  CNT_W  soln1 pump-on cycles (0 = skip phase).
REQ-008 Port: t_dose2  input  CNT_W  soln2 pump-on cycles (0 = skip phase).
REQ-009 Port: t_dose3  input  CNT_W  soln3 pump-on cycles (0 = skip phase).
REQ-010 Port: t_mix  input  CNT_W  settle cycles, all pumps off (0 = skip phase).
REQ-011 Port: pump_en  output  3  pump enable; bit0 soln1, bit1 soln2, bit2 soln3.
REQ-012 Port: flush_en  output  1  flush valve enable toward out.
REQ-013 Port: busy  output  1  high while a run is in progress.
REQ-014 Port: done  output  1  one-cycle pulse at the end of a completed or aborted run.
REQ-015 Port: err  output  1  sticky abort flag; cleared by the next accepted start.

Function
REQ-016 States SHALL be IDLE, DOSE1, DOSE2, DOSE3, MIX, FLUSH, DONE; all outputs registered.
REQ-017 start=1 in IDLE at edge k SHALL latch t_dose1..3 and t_mix, clear err, and enter the first non-zero phase in order DOSE1, DOSE2, DOSE3, MIX, with FLUSH as the fallback, at edge k+1.
REQ-018 Each DOSEn/MIX phase SHALL last exactly its latched count of cycles, then move to the next non-zero phase, else FLUSH; zero-length phases consume no cycles.
REQ-019 In DOSEn only pump_en[n-1]=1; in FLUSH only flush_en=1; otherwise pump_en=0 and flush_en=0. At most one of these four bits SHALL be high in any cycle.
REQ-020 FLUSH SHALL last exactly FLUSH_CYC cycles, then go to DONE for one cycle (done=1, busy=0), then return to IDLE.
REQ-021 busy SHALL be 1 in every cycle from the first phase cycle through the last FLUSH cycle, and 0 in IDLE and DONE.
REQ-022 A start pulse that arrives while not in IDLE SHALL be ignored and SHALL NOT be queued; changes to the duration inputs during a run SHALL have no effect.
REQ-023 abort=1 in DOSEn/MIX SHALL force FLUSH at the next edge, with the full FLUSH_CYC length, and set err=1.
REQ-024 abort SHALL be ignored in IDLE, FLUSH and DONE; if start and abort are both 1 in IDLE, start SHALL win.
REQ-025 Counters SHALL count down from the latched value to 1 and never wrap; a maximum count of 2^CNT_W-1 SHALL be legal.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, pump_en=0, flush_en=0, busy=0, done=0, err=0 and clear all counters and latched durations, including mid-run (no flush is performed).
REQ-027 After rst_n is released, the first start SHALL be accepted at the first rising edge.

Structure
REQ-028 The state enum, CNT_W default and FLUSH_CYC default SHALL live in shared package smart_toilet_pkg.
REQ-029 Phase timing SHALL be a single reusable sub-module, phase_timer (load, count value, expire pulse), instanced once.

Verification
REQ-030 t_dose=3/2/1, t_mix=4, FLUSH_CYC=5, start at cycle 0 -> pump_en=001 on cycles 1-3, 010 on 4-5, 100 on 6, all off on 7-10, flush_en on 11-15, done on 16.
REQ-031 t_dose=0/0/0, t_mix=0, start -> flush_en the very next cycle for FLUSH_CYC cycles, then done; pump_en never asserted.
REQ-032 abort in the 2nd cycle of DOSE2 -> flush_en the next cycle for the full FLUSH_CYC, err=1 held until the next start, done pulses once.
REQ-033 start re-pulsed mid-MIX and abort pulsed during FLUSH -> both ignored; timing identical to an undisturbed run.
REQ-034 rst_n low in the middle of DOSE3 -> all outputs 0 immediately without waiting for a clock edge; after release a start gives normal timing.
REQ-035 t_dose1=2^CNT_W-1 -> pump_en[0] high exactly that many cycles, no counter wrap.
